// File: rtl/bp_pkg.sv
// Shared types and helpers for the dynamic branch predictor: control-transfer kinds,
// the per-entry header and the saturating direction-counter step.
package bp_pkg;

    // 2'b11 is reserved; the predictor treats it like JUMP.
    typedef enum logic [1:0] {
        BRANCH = 2'b00,
        JUMP   = 2'b01,
        RET    = 2'b10,
        RSVD   = 2'b11
    } bp_kind_t;

    typedef struct packed {
        logic     valid;
        bp_kind_t kind;
    } bp_entry_hdr_t;

    // Widest direction counter the helper supports; callers cast down to their CNT_W.
    localparam int unsigned CtrWMax = 8;

    function automatic logic [CtrWMax-1:0] ctr_step(input logic [CtrWMax-1:0] ctr,
                                                    input int unsigned        width,
                                                    input logic               up);
        logic [CtrWMax-1:0] ctr_max;
        ctr_max = CtrWMax'((32'd1 << width) - 32'd1);
        if (up) begin
            return (ctr >= ctr_max) ? ctr : ctr + CtrWMax'(1);
        end
        return (ctr == '0) ? ctr : ctr - CtrWMax'(1);
    endfunction

endpackage

// File: rtl/bp_ras.sv
// Circular return-address stack: push/pop with synchronous active-low reset; a push when
// full overwrites the oldest entry, a pop when empty is ignored, push+pop replaces the top.
module bp_ras #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4,
    localparam int unsigned PtrW     = $clog2(RAS_DEPTH),
    localparam int unsigned CntW     = $clog2(RAS_DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [XLEN-1:0] data_i,
    output logic [XLEN-1:0] top_o,
    output logic [CntW-1:0] count_o
);

    localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);
    localparam logic [CntW-1:0] CntMax = CntW'(RAS_DEPTH);

    logic [XLEN-1:0] stack_q [RAS_DEPTH];
    logic [XLEN-1:0] stack_d [RAS_DEPTH];
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] top_idx;
    logic            do_pop;

    // ptr_q names the next free slot; the top lives one below it.
    assign top_idx = ptr_q - PtrOne;
    assign top_o   = stack_q[top_idx];
    assign count_o = count_q;
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        stack_d = stack_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        if (push_i && do_pop) begin
            stack_d[top_idx] = data_i;
        end else if (push_i) begin
            stack_d[ptr_q] = data_i;
            ptr_d          = ptr_q + PtrOne;
            if (count_q != CntMax) begin
                count_d = count_q + CntOne;
            end
        end else if (do_pop) begin
            ptr_d   = top_idx;
            count_d = count_q - CntOne;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            stack_q <= stack_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters: combinational lookup on
// pcF, training from resolved E-stage transfers. Define BP_RAS_EN to add the return-address stack.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ENTRIES   = 16,
    parameter int unsigned CNT_W     = 2,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pcF,
    output logic            pred_takenF,
    output logic [XLEN-1:0] pred_nextF,
    input  logic            upd_validE,
    input  logic [XLEN-1:0] upd_pcE,
    input  bp_kind_t        upd_kindE,
    input  logic            upd_takenE,
    input  logic [XLEN-1:0] upd_targetE,
    input  logic            upd_callE,
    input  logic [XLEN-1:0] upd_pc4E
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;
    localparam logic [CNT_W-1:0] CtrInit = CNT_W'(32'd1 << (CNT_W - 1));

    typedef struct packed {
        bp_entry_hdr_t    hdr;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        logic [CNT_W-1:0] ctr;
    } entry_t;

    entry_t tab_q [ENTRIES];
    entry_t tab_d [ENTRIES];

    logic [IDX_W-1:0] idx_f, idx_e;
    logic [TAG_W-1:0] tag_f, tag_e;
    logic             hit_f, hit_e;
    logic             ras_ok;
    logic [XLEN-1:0]  ras_top;
    logic             unused_bits;

    // ---------------------------------------------------------------- lookup
    assign idx_f = pcF[IDX_W+1:2];
    assign tag_f = pcF[XLEN-1:IDX_W+2];
    assign hit_f = tab_q[idx_f].hdr.valid && (tab_q[idx_f].tag == tag_f);

    assign pred_takenF = hit_f &&
                         ((tab_q[idx_f].hdr.kind != BRANCH) || tab_q[idx_f].ctr[CNT_W-1]);

    always_comb begin
        pred_nextF = pcF + XLEN'(4);
        if (pred_takenF) begin
            if ((tab_q[idx_f].hdr.kind == RET) && ras_ok) begin
                pred_nextF = ras_top;
            end else begin
                pred_nextF = tab_q[idx_f].target;
            end
        end
    end

    // ---------------------------------------------------------------- training
    assign idx_e = upd_pcE[IDX_W+1:2];
    assign tag_e = upd_pcE[XLEN-1:IDX_W+2];
    assign hit_e = tab_q[idx_e].hdr.valid && (tab_q[idx_e].tag == tag_e);

    always_comb begin
        tab_d = tab_q;
        if (upd_validE) begin
            if (hit_e && (upd_kindE == BRANCH)) begin
                tab_d[idx_e].ctr = CNT_W'(ctr_step(CtrWMax'(tab_q[idx_e].ctr), CNT_W,
                                                   upd_takenE));
                if (upd_takenE) begin
                    tab_d[idx_e].target = upd_targetE;
                end
            end else if (hit_e) begin
                tab_d[idx_e].target   = upd_targetE;
                tab_d[idx_e].hdr.kind = upd_kindE;
            end else if (upd_takenE || (upd_kindE != BRANCH)) begin
                // Direct-mapped allocate: any alias at this index is simply replaced.
                tab_d[idx_e].hdr.valid = 1'b1;
                tab_d[idx_e].hdr.kind  = upd_kindE;
                tab_d[idx_e].tag       = tag_e;
                tab_d[idx_e].target    = upd_targetE;
                tab_d[idx_e].ctr       = CtrInit;
            end
        end
    end

    // Reset clears only the valid bits; the rest of each entry is don't-care until allocated.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tab_q[i].hdr.valid <= 1'b0;
            end
        end else begin
            tab_q <= tab_d;
        end
    end

    // ---------------------------------------------------------------- return stack
`ifdef BP_RAS_EN
    localparam int unsigned RAS_CNT_W = $clog2(RAS_DEPTH + 1);

    logic                 ras_push, ras_pop;
    logic [RAS_CNT_W-1:0] ras_count;

    assign ras_push = upd_validE && upd_callE;
    assign ras_pop  = upd_validE && (upd_kindE == RET);
    assign ras_ok   = (ras_count != '0);

    bp_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (ras_push),
        .pop_i   (ras_pop),
        .data_i  (upd_pc4E),
        .top_o   (ras_top),
        .count_o (ras_count)
    );

    assign unused_bits = ^{pcF[1:0], upd_pcE[1:0]};
`else
    // Without the stack, RET entries fall back to their stored target like JUMP.
    assign ras_ok      = 1'b0;
    assign ras_top     = '0;
    assign unused_bits = ^{pcF[1:0], upd_pcE[1:0], upd_callE, upd_pc4E, (RAS_DEPTH != 0)};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed scenarios then random traffic, checked
// against a table/queue reference model. Honours BP_RAS_EN the same way the design does.
module tb_branch_predictor;
    import bp_pkg::*;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned ENTRIES   = 16;
    localparam int unsigned CNT_W     = 2;
    localparam int unsigned RAS_DEPTH = 4;
    localparam int unsigned IDX_W     = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [XLEN-1:0] pcF = '0;
    logic            pred_takenF;
    logic [XLEN-1:0] pred_nextF;
    logic            upd_validE = 1'b0;
    logic [XLEN-1:0] upd_pcE = '0;
    bp_kind_t        upd_kindE = BRANCH;
    logic            upd_takenE = 1'b0;
    logic [XLEN-1:0] upd_targetE = '0;
    logic            upd_callE = 1'b0;
    logic [XLEN-1:0] upd_pc4E = '0;

    always #5 clk = ~clk;

    branch_predictor #(
        .XLEN      (XLEN),
        .ENTRIES   (ENTRIES),
        .CNT_W     (CNT_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pcF         (pcF),
        .pred_takenF (pred_takenF),
        .pred_nextF  (pred_nextF),
        .upd_validE  (upd_validE),
        .upd_pcE     (upd_pcE),
        .upd_kindE   (upd_kindE),
        .upd_takenE  (upd_takenE),
        .upd_targetE (upd_targetE),
        .upd_callE   (upd_callE),
        .upd_pc4E    (upd_pc4E)
    );

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] next;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: plain per-index records and a bounded queue for the return stack.
    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    int unsigned m_target [ENTRIES];
    int unsigned m_kind   [ENTRIES];
    int unsigned m_ctr    [ENTRIES];
    logic [31:0] m_ras[$];

    // Applies the effect of the clock edge that just sampled the currently driven inputs.
    function automatic void model_edge();
        int unsigned idx, tag, k, cmax;
        bit hit;
        if (!rst_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) m_valid[i] = 0;
            m_ras.delete();
            return;
        end
        if (!upd_validE) return;
        idx  = (upd_pcE >> 2) % ENTRIES;
        tag  = upd_pcE >> (IDX_W + 2);
        k    = int'(upd_kindE);
        cmax = (1 << CNT_W) - 1;
        hit  = m_valid[idx] && (m_tag[idx] == tag);
        if (hit && k == 0) begin
            if (upd_takenE) begin
                if (m_ctr[idx] < cmax) m_ctr[idx]++;
                m_target[idx] = upd_targetE;
            end else if (m_ctr[idx] > 0) begin
                m_ctr[idx]--;
            end
        end else if (hit) begin
            m_target[idx] = upd_targetE;
            m_kind[idx]   = k;
        end else if (upd_takenE || k != 0) begin
            m_valid[idx]  = 1;
            m_tag[idx]    = tag;
            m_target[idx] = upd_targetE;
            m_kind[idx]   = k;
            m_ctr[idx]    = 1 << (CNT_W - 1);
        end
`ifdef BP_RAS_EN
        if (k == 2 && m_ras.size() > 0) void'(m_ras.pop_back());
        if (upd_callE) begin
            m_ras.push_back(upd_pc4E);
            if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
        end
`endif
    endfunction

    function automatic void push_expect();
        exp_t e;
        int unsigned idx, tag;
        bit hit;
        idx     = (pcF >> 2) % ENTRIES;
        tag     = pcF >> (IDX_W + 2);
        hit     = m_valid[idx] && (m_tag[idx] == tag);
        e.pc    = pcF;
        e.taken = hit && (m_kind[idx] != 0 || m_ctr[idx] >= (1 << (CNT_W - 1)));
        e.next  = pcF + 32'd4;
        if (e.taken) begin
            e.next = m_target[idx];
`ifdef BP_RAS_EN
            if (m_kind[idx] == 2 && m_ras.size() > 0) e.next = m_ras[$];
`endif
        end
        sb_q.push_back(e);
    endfunction

    task automatic step(input logic [31:0] pc, input logic rst, input logic uv,
                        input logic [31:0] upc, input int kind, input logic tk,
                        input logic [31:0] tgt, input logic call, input logic [31:0] p4);
        logic [1:0] kb;
        @(posedge clk);
        #1;
        model_edge();
        kb          = kind[1:0];
        pcF         = pc;
        rst_n       = rst;
        upd_validE  = uv;
        upd_pcE     = upc;
        upd_kindE   = bp_kind_t'(kb);
        upd_takenE  = tk;
        upd_targetE = tgt;
        upd_callE   = call;
        upd_pc4E    = p4;
        push_expect();
    endtask

    task automatic look(input logic [31:0] pc);
        step(pc, 1'b1, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] upc, input int kind,
                       input logic tk, input logic [31:0] tgt);
        step(pc, 1'b1, 1'b1, upc, kind, tk, tgt, 1'b0, 32'h0);
    endtask

    // Monitor: outputs are combinational, so compare mid-cycle against the queued expectation.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            vectors++;
            if (pred_takenF !== e.taken || pred_nextF !== e.next) begin
                miscompares++;
                $display("FAIL lookup pc=%h: got taken=%b next=%h, want taken=%b next=%h",
                         e.pc, pred_takenF, pred_nextF, e.taken, e.next);
            end
        end
    end

    initial begin
        logic [31:0] rpc, rupc;
        int          rk;
        logic        rtk;

        step(32'h100, 1'b0, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(32'h100, 1'b0, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0, 32'h0);
        look(32'h100);
        upd(32'h100, 32'h100, 0, 1'b1, 32'h80);
        look(32'h100);
        for (int i = 0; i < 5; i++) upd(32'h100, 32'h100, 0, 1'b0, 32'h80);
        for (int i = 0; i < 4; i++) upd(32'h100, 32'h100, 0, 1'b1, 32'h80);
        look(32'h100);

        upd(32'h100, 32'h140, 1, 1'b1, 32'h200);
        look(32'h100);
        look(32'h140);
        upd(32'h180, 32'h180, 0, 1'b0, 32'h999C);
        look(32'h180);
        upd(32'h140, 32'h140, 1, 1'b1, 32'h240);
        look(32'h140);

        step(32'h140, 1'b0, 1'b1, 32'h100, 0, 1'b1, 32'h80, 1'b0, 32'h0);
        look(32'h140);
        look(32'h100);

        // Return-stack scenarios; without BP_RAS_EN the stored RET target is expected.
        upd(32'h400, 32'h400, 2, 1'b1, 32'h600);
        step(32'h400, 1'b1, 1'b1, 32'h300, 1, 1'b1, 32'h500, 1'b1, 32'h304);
        look(32'h400);
        for (int i = 0; i < 5; i++) begin
            step(32'h400, 1'b1, 1'b1, 32'h300, 1, 1'b1, 32'h500, 1'b1, 32'hA0 + 32'(i));
        end
        for (int i = 0; i < 5; i++) upd(32'h400, 32'h400, 2, 1'b1, 32'h600);
        look(32'h400);

        for (int n = 0; n < 1500; n++) begin
            rpc  = 32'h1000 | (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
            rupc = 32'h1000 | (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
            rk   = int'($urandom_range(0, 3));
            rtk  = (rk == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            step(rpc, ($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), rupc, rk, rtk,
                 32'($urandom) & 32'hFFFF_FFFC, ($urandom_range(0, 3) == 0), rupc + 32'd4);
        end

        @(posedge clk);
        #1;
        model_edge();
        upd_validE = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
